// File: rtl/lcd_bus_receiver.sv
// Captures a 4-bit HD44780-style LCD bus and queues reassembled {rs, byte} entries in a FWFT FIFO.
// Push lands 3 clocks after E is first sampled low; pushes while full are dropped and flagged unless popped together.
module lcd_bus_receiver #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_50mhz,
  input  logic                     rst_n,
  input  logic                     LCDRS,
  input  logic                     LCDRW,
  input  logic                     LCDE,
  input  logic [3:0]               LCDDAT,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [8:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     four_bit_mode,
  output logic                     overflow,
  output logic                     rs_mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    MODE8 = 2'd0,
    HI4   = 2'd1,
    LO4   = 2'd2
  } state_e;

  // Two-flop synchronizers on every bus pin, plus one more stage on E for edge detect
  logic [1:0] rs_sync_q;
  logic [1:0] rw_sync_q;
  logic [1:0] e_sync_q;
  logic [3:0] dat_sync1_q;
  logic [3:0] dat_sync2_q;
  logic       e_d_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rs_sync_q   <= '0;
      rw_sync_q   <= '0;
      e_sync_q    <= '0;
      dat_sync1_q <= '0;
      dat_sync2_q <= '0;
      e_d_q       <= 1'b0;
    end else begin
      rs_sync_q   <= {rs_sync_q[0], LCDRS};
      rw_sync_q   <= {rw_sync_q[0], LCDRW};
      e_sync_q    <= {e_sync_q[0], LCDE};
      dat_sync1_q <= LCDDAT;
      dat_sync2_q <= dat_sync1_q;
      e_d_q       <= e_sync_q[1];
    end
  end

  logic       rs_s;
  logic       rw_s;
  logic [3:0] dat_s;
  logic       strobe;
  logic       wr_stb;
  logic       rd_stb;

  assign rs_s   = rs_sync_q[1];
  assign rw_s   = rw_sync_q[1];
  assign dat_s  = dat_sync2_q;
  assign strobe = e_d_q & ~e_sync_q[1];
  assign wr_stb = strobe & ~rw_s;
  assign rd_stb = strobe & rw_s;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] hi_q;
  logic       hi_rs_q;
  logic       hi_wr_q;

  logic       push;
  logic [8:0] push_dat;
  logic       mis_set;
  logic       hi_load;
  logic       hi_kill;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE8;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE8: if (wr_stb && !rs_s && dat_s == 4'h2) state_d = HI4;
      HI4:   if (strobe) state_d = LO4;
      // Function set with DL=1 drops the controller back to 8-bit mode
      LO4: begin
        if (strobe) begin
          if (wr_stb && hi_wr_q && !hi_rs_q && hi_q == 4'h3) state_d = MODE8;
          else state_d = HI4;
        end
      end
      default: state_d = MODE8;
    endcase
  end

  always_comb begin
    push          = 1'b0;
    push_dat      = '0;
    mis_set       = 1'b0;
    hi_load       = 1'b0;
    hi_kill       = 1'b0;
    four_bit_mode = (state_q != MODE8);
    case (state_q)
      MODE8: begin
        push     = wr_stb;
        push_dat = {rs_s, dat_s, 4'h0};
      end
      HI4: begin
        hi_load = wr_stb;
        hi_kill = rd_stb;
      end
      LO4: begin
        push     = wr_stb & hi_wr_q;
        push_dat = {hi_rs_q, hi_q, dat_s};
        mis_set  = wr_stb & hi_wr_q & (rs_s != hi_rs_q);
      end
      default: ;
    endcase
  end

  // A read in the high-nibble slot poisons the pair so the following low nibble is discarded
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      hi_rs_q <= 1'b0;
      hi_wr_q <= 1'b0;
    end else if (hi_load) begin
      hi_q    <= dat_s;
      hi_rs_q <= rs_s;
      hi_wr_q <= 1'b1;
    end else if (hi_kill) begin
      hi_wr_q <= 1'b0;
    end
  end

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign count   = count_q;
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign rd_data = empty ? 9'h000 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_50mhz) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      rs_mismatch <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (mis_set)      rs_mismatch <= 1'b1;
      else if (err_clr) rs_mismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized bench for lcd_bus_receiver: bus-cycle driver, behavioural model and scoreboard monitor.
module tb_lcd_bus_receiver;
  localparam int DEPTH = 16;

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       LCDRS = 1'b0;
  logic       LCDRW = 1'b0;
  logic       LCDE = 1'b0;
  logic [3:0] LCDDAT = 4'h0;
  logic       mon_rd = 1'b0;
  logic       stim_rd = 1'b0;
  logic       rd_en;
  logic       err_clr = 1'b0;
  logic [8:0] rd_data;
  logic       empty;
  logic       full;
  logic [$clog2(DEPTH):0] count;
  logic       four_bit_mode;
  logic       overflow;
  logic       rs_mismatch;

  assign rd_en = mon_rd | stim_rd;

  lcd_bus_receiver #(.DEPTH(DEPTH)) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDE(LCDE),
    .LCDDAT(LCDDAT), .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .four_bit_mode(four_bit_mode), .overflow(overflow),
    .rs_mismatch(rs_mismatch)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model: expected queue contents plus the controller's view of the bus protocol
  logic [8:0] ref_q[$];
  bit         m_four, m_have_hi, m_hi_wr, m_hi_rs, m_ovf, m_mis;
  logic [3:0] m_hi;
  bit         drain_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    ref_q.delete();
    m_four = 0; m_have_hi = 0; m_hi_wr = 0; m_hi_rs = 0; m_hi = 4'h0;
    m_ovf = 0; m_mis = 0;
  endtask

  task automatic model_push(input logic [8:0] val, input bit popping);
    if (popping && ref_q.size() > 0) begin
      check("head_at_full_pop", rd_data, ref_q[0]);
      void'(ref_q.pop_front());
      ref_q.push_back(val);
    end else if (ref_q.size() == DEPTH) begin
      m_ovf = 1;
    end else begin
      ref_q.push_back(val);
    end
  endtask

  task automatic model_strobe(input bit rs, input bit rw, input logic [3:0] dat, input bit popping);
    if (!m_four) begin
      if (!rw) begin
        model_push({rs, dat, 4'h0}, popping);
        if (!rs && dat == 4'h2) m_four = 1;
      end
    end else if (!m_have_hi) begin
      m_have_hi = 1;
      m_hi_wr = !rw;
      if (!rw) begin m_hi = dat; m_hi_rs = rs; end
    end else begin
      m_have_hi = 0;
      if (!rw && m_hi_wr) begin
        model_push({m_hi_rs, m_hi, dat}, popping);
        if (rs != m_hi_rs) m_mis = 1;
        if (!m_hi_rs && m_hi == 4'h3) m_four = 0;
      end
    end
  endtask

  // One full bus cycle; samples empty/four_bit_mode after each of the three edges following the E fall
  task automatic bus_cycle(input bit rs, input bit rw, input logic [3:0] dat, input bit pop3,
                           output logic [2:0] emp_h, output logic [2:0] fbm_h);
    @(negedge clk_50mhz);
    LCDRS = rs; LCDRW = rw; LCDDAT = dat; LCDE = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    LCDE = 1'b0;
    model_strobe(rs, rw, dat, pop3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      stim_rd = 1'b0;
      emp_h[i] = empty;
      fbm_h[i] = four_bit_mode;
      if (pop3 && i == 1) stim_rd = 1'b1;
    end
  endtask

  task automatic nib(input bit rs, input bit rw, input logic [3:0] dat);
    logic [2:0] e, f;
    bus_cycle(rs, rw, dat, 1'b0, e, f);
  endtask

  task automatic rand_wr();
    nib(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic clear_err();
    @(negedge clk_50mhz);
    err_clr = 1'b1;
    @(negedge clk_50mhz);
    err_clr = 1'b0;
    m_ovf = 0; m_mis = 0;
  endtask

  task automatic wait_drained();
    int t = 0;
    drain_en = 1'b1;
    while ((!empty || ref_q.size() != 0) && t < 200) begin
      @(negedge clk_50mhz);
      t++;
    end
    check("drain_in_time", int'(t < 200), 1);
    drain_en = 1'b0;
    @(negedge clk_50mhz);
  endtask

  task automatic check_reset_vals();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_four_bit", four_bit_mode, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rs_mismatch", rs_mismatch, 0);
    check("rst_rd_data", rd_data, 0);
  endtask

  // Scoreboard monitor: pops the DUT whenever draining is enabled and compares with the model queue
  initial begin
    forever begin
      @(negedge clk_50mhz);
      mon_rd = 1'b0;
      if (drain_en && rst_n && !empty) begin
        if (ref_q.size() == 0) check("unexpected_entry", ref_q.size(), 1);
        else check("rd_data", rd_data, ref_q.pop_front());
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    logic [2:0] eh, fh;
    int guard;
    model_reset();
    repeat (3) @(negedge clk_50mhz);
    check_reset_vals();
    rst_n = 1'b1;

    // 8-bit init sequence; first cycle also measures push latency
    bus_cycle(1'b0, 1'b0, 4'h3, 1'b0, eh, fh);
    check("latency_empty", eh, 3'b011);
    nib(1'b0, 1'b0, 4'h3);
    nib(1'b0, 1'b0, 4'h3);
    bus_cycle(1'b0, 1'b0, 4'h2, 1'b0, eh, fh);
    check("four_bit_rise", fh, 3'b100);
    check("init_count", count, 4);
    wait_drained();

    bus_cycle(1'b1, 1'b0, 4'h4, 1'b0, eh, fh);
    check("no_entry_mid_byte", eh, 3'b111);
    nib(1'b1, 1'b0, 4'h1);
    nib(1'b0, 1'b0, 4'h2);
    nib(1'b0, 1'b0, 4'h8);
    check("pair_count", count, 2);
    wait_drained();

    nib(1'b0, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'h5);
    check("rs_mismatch_set", rs_mismatch, 1);
    wait_drained();
    clear_err();
    check("rs_mismatch_clr", rs_mismatch, 0);

    // Random traffic including reads, drained continuously
    drain_en = 1'b1;
    for (int i = 0; i < 60; i++)
      nib(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    wait_drained();
    check("rand_four_bit", four_bit_mode, int'(m_four));
    check("rand_rs_mismatch", rs_mismatch, int'(m_mis));
    check("rand_overflow", overflow, 0);

    // Fill past capacity
    clear_err();
    guard = 0;
    while (!m_ovf && guard < 200) begin rand_wr(); guard++; end
    check("fill_full", full, 1);
    check("fill_count", count, DEPTH);
    check("fill_overflow", overflow, 1);
    clear_err();
    check("overflow_clr", overflow, 0);

    guard = 0;
    while (m_four && !(m_have_hi && m_hi_wr) && guard < 4) begin rand_wr(); guard++; end
    bus_cycle(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)), 1'b1, eh, fh);
    check("pushpop_count", count, DEPTH);
    check("pushpop_full", full, 1);
    check("pushpop_overflow", overflow, 0);
    wait_drained();

    // Second fill crosses the pointer wrap
    guard = 0;
    while (ref_q.size() < 12 && guard < 200) begin rand_wr(); guard++; end
    check("refill_count", count, ref_q.size());
    wait_drained();

    // Read in high slot discards the pair; function set returns to 8-bit mode
    guard = 0;
    while (!(m_four && !m_have_hi) && guard < 6) begin
      if (!m_four) nib(1'b0, 1'b0, 4'h2);
      else nib(1'b1, 1'b0, 4'h0);
      guard++;
    end
    wait_drained();
    nib(1'b0, 1'b1, 4'h0);
    bus_cycle(1'b1, 1'b0, 4'h6, 1'b0, eh, fh);
    check("read_pair_discard", eh, 3'b111);
    nib(1'b0, 1'b0, 4'h3);
    bus_cycle(1'b0, 1'b0, 4'h0, 1'b0, eh, fh);
    check("four_bit_fall", fh, 3'b011);
    check("func_set_count", count, 1);
    check("func_set_head", rd_data, 9'h030);
    wait_drained();

    // Reset between the two nibbles of a byte
    nib(1'b0, 1'b0, 4'h2);
    nib(1'b1, 1'b0, 4'h9);
    check("mid_byte_four_bit", four_bit_mode, 1);
    @(negedge clk_50mhz);
    rst_n = 1'b0;
    #2;
    check_reset_vals();
    model_reset();
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    nib(1'b1, 1'b0, 4'hA);
    check("post_reset_head", rd_data, 9'h1A0);
    check("post_reset_four_bit", four_bit_mode, 0);
    wait_drained();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
